ctl_write_sequencer: RTL and testbench

- Buffers video-pipeline control register writes and replays them as Avalon-MM write transfers on the control port.
- Sits directly upstream of the control-bus combiner that decodes address[8:7] into scaler, mixer and video targets.
- Lets the HPS/CPU-side producer post writes without stalling on downstream waitrequest.
- Can hold off issuing writes (e.g. until vblank) so that multi-register updates land together.

---
 rtl/ctl_seq_pkg.sv | 25 ++
 rtl/ctl_cmd_fifo.sv | 71 +++++++
 rtl/ctl_write_sequencer.sv | 142 ++++++++++++++
 tb/tb_ctl_write_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_seq_pkg.sv
// Shared types for the control-write sequencer: command record, FSM states and
// default bus widths matching the downstream control-bus combiner.
package ctl_seq_pkg;

  localparam int CTL_AW = 9;
  localparam int CTL_DW = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    XFER = ST_XFER
  } seq_state_e;

  typedef struct packed {
    logic [CTL_AW-1:0] addr;
    logic [CTL_DW-1:0] data;
  } ctl_cmd_t;

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ctl_cmd_fifo.sv
// Synchronous show-ahead FIFO: exposes the head and the entry behind it so a
// consumer can chain pops back-to-back. Ready is registered from the next level.
module ctl_cmd_fifo #(
  parameter int  DEPTH = 16,
  parameter int  W     = 41,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [W-1:0]  o_head_nxt,
  output logic          o_ready,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  assign w_empty      = (r_level == '0);
  assign w_push       = i_push & r_ready;
  assign w_pop        = i_pop & ~w_empty;
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(1);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Ready looks at the post-edge level so a pop while full never opens it early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LW'(DEPTH));
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_head_nxt = r_mem[w_rd_ptr_nxt];
  assign o_ready    = r_ready;
  assign o_empty    = w_empty;
  assign o_level    = r_level;

endmodule

// File: rtl/ctl_write_sequencer.sv
// Posts buffered control-register writes as Avalon-MM write transfers, with a
// hold input to batch updates. CTL_SEQ_TIMEOUT_EN adds a waitrequest abort timer.
module ctl_write_sequencer
  import ctl_seq_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter int  AW      = CTL_AW,
  parameter int  DW      = CTL_DW,
  parameter int  TIMEOUT = 1023,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          cmd_ready,
  input  logic          hold,
  output logic [AW-1:0] address,
  output logic          write,
  output logic [DW-1:0] writedata,
  input  logic          waitrequest,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          timeout_err,
  input  logic          clr_err
);

  localparam int CW = AW + DW;

  logic [CW-1:0] w_head;
  logic [CW-1:0] w_head_nxt;
  logic [LW-1:0] w_level;
  logic          w_empty;
  logic          w_done;
  logic          w_abort;
  logic          w_pop;
  logic          w_more;

  seq_state_e    r_state;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  ctl_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (cmd_valid),
    .i_wdata    ({cmd_addr, cmd_data}),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_head_nxt (w_head_nxt),
    .o_ready    (cmd_ready),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  assign w_done = r_write & ~waitrequest;
  assign w_pop  = w_done | w_abort;
  // Only entries already stored behind the head can chain; a same-edge push waits a cycle.
  assign w_more = (w_level > LW'(1));

`ifdef CTL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_err;
  logic          w_stall;

  assign w_stall = r_write & waitrequest;
  assign w_abort = w_stall & (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_cnt <= (w_stall & ~w_abort) ? r_tmo_cnt + TW'(1) : '0;
      if (w_abort)      r_tmo_err <= 1'b1;
      else if (clr_err) r_tmo_err <= 1'b0;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  logic        w_unused_clr;
  logic [31:0] w_unused_tmo;

  assign w_unused_clr = clr_err;
  assign w_unused_tmo = 32'(TIMEOUT);
  assign w_abort      = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty && !hold) begin
            r_addr  <= w_head[CW-1:DW];
            r_data  <= w_head[DW-1:0];
            r_write <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_done) begin
            if (w_more && !hold) begin
              r_addr <= w_head_nxt[CW-1:DW];
              r_data <= w_head_nxt[DW-1:0];
            end else begin
              r_write <= 1'b0;
              r_state <= IDLE;
            end
          end else if (w_abort) begin
            r_write <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_write <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign address   = r_addr;
  assign writedata = r_data;
  assign write     = r_write;
  assign level     = w_level;
  assign busy      = r_write | (w_level != '0);

endmodule

// File: tb/tb_ctl_write_sequencer.sv
// Directed + randomized bench for ctl_write_sequencer against a queue-based
// model of accepted-but-not-completed commands.
module tb_ctl_write_sequencer;
  import ctl_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [8:0]    cmd_addr;
  logic [31:0]   cmd_data;
  logic          cmd_ready;
  logic          hold;
  logic [8:0]    address;
  logic          write;
  logic [31:0]   writedata;
  logic          waitrequest;
  logic [LW-1:0] level;
  logic          busy;
  logic          timeout_err;
  logic          clr_err;

  int       chk   = 0;
  int       errs  = 0;
  int       ncomp = 0;
  int       ndrop = 0;
  int       tcnt  = 0;
  bit       errm  = 1'b0;
  ctl_cmd_t q[$];

  ctl_write_sequencer #(
    .DEPTH   (DEPTH),
    .AW      (9),
    .DW      (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .hold        (hold),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .level       (level),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update the model, check 1ns after.
  task automatic tick();
    logic        acc, comp, abort, pw, pwr, ph;
    logic [8:0]  pa;
    logic [31:0] pd;
    ctl_cmd_t    nc;
    acc  = cmd_valid & cmd_ready;
    comp = write & ~waitrequest;
    pw = write; pwr = waitrequest; ph = hold; pa = address; pd = writedata;
    nc.addr = cmd_addr; nc.data = cmd_data;
    abort = 1'b0;
`ifdef CTL_SEQ_TIMEOUT_EN
    if (write && waitrequest) tcnt++;
    else tcnt = 0;
    if (tcnt == TMO) begin abort = 1'b1; tcnt = 0; end
    if (abort)        errm = 1'b1;
    else if (clr_err) errm = 1'b0;
`endif
    @(posedge clk); #1;
    if (comp || abort) begin
      check("xfer_nonempty", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        if (comp) begin
          check("xfer_addr", pa, q[0].addr);
          check("xfer_data", pd, q[0].data);
          ncomp++;
        end else ndrop++;
        void'(q.pop_front());
      end
    end
    if (acc) q.push_back(nc);
    if (pw && pwr && !abort) begin
      check("stall_write", write, 1'b1);
      check("stall_addr", address, pa);
      check("stall_data", writedata, pd);
    end
    if (abort) check("abort_drop", write, 1'b0);
    if (!pw && write) check("start_hold", ph, 1'b0);
    check("level", level, q.size());
    check("ready", cmd_ready, q.size() < DEPTH);
    check("busy", busy, write || q.size() != 0);
    check("tmo_err", timeout_err, errm);
  endtask

  task automatic push(input logic [8:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    hold = 1'b0; waitrequest = 1'b0; clr_err = 1'b0;
    #2;
    check("rst_write", write, 0);
    check("rst_addr", address, 0);
    check("rst_data", writedata, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    check("rst_ready", cmd_ready, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("ready_pre_clk", cmd_ready, 0);
    tick();
    check("ready_post_clk", cmd_ready, 1);

    // single write
    push(9'h085, 32'h12345678);
    check("t1_wait", write, 0);
    check("t1_lvl1", level, 1);
    tick();
    check("t1_wr", write, 1);
    check("t1_addr", address, 9'h085);
    check("t1_data", writedata, 32'h12345678);
    tick();
    check("t1_wr_drop", write, 0);
    check("t1_lvl0", level, 0);
    check("t1_busy", busy, 0);

    // stall then back-to-back drain
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) push(9'(256 + i), $urandom);
    repeat (5) tick();
    check("t2_stall_addr", address, 9'h100);
    waitrequest = 1'b0;
    c0 = ncomp;
    repeat (2) begin tick(); check("t2_b2b", write, 1); end
    tick();
    check("t2_ncomp", ncomp - c0, 3);
    check("t2_idle", write, 0);

    // fill to full under hold
    hold = 1'b1;
    for (int i = 0; i < 17; i++) push(9'($urandom), $urandom);
    check("t3_lvl", level, 16);
    check("t3_ready", cmd_ready, 0);
    check("t3_nowr", write, 0);
    hold = 1'b0;
    c0 = ncomp;
    tick();
    check("t3_start", write, 1);
    tick();
    check("t3_ready_back", cmd_ready, 1);
    check("t3_lvl15", level, 15);
    for (int i = 0; i < 40 && (q.size() != 0 || write); i++) tick();
    check("t3_drained", level, 0);
    check("t3_ncomp", ncomp - c0, 16);

    // hold raised mid-burst
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(9'(64 + i), $urandom);
    hold = 1'b0;
    c0 = ncomp;
    tick(); tick();
    hold = 1'b1;
    tick();
    check("t4_wr_off", write, 0);
    check("t4_lvl2", level, 2);
    tick();
    check("t4_held", write, 0);
    hold = 1'b0;
    for (int i = 0; i < 10 && (q.size() != 0 || write); i++) tick();
    check("t4_ncomp", ncomp - c0, 4);

    // reset mid-transfer
    waitrequest = 1'b1;
    push(9'h011, 32'h1);
    push(9'h022, 32'h2);
    check("t5_wr", write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_wr_rst", write, 0);
    check("t5_lvl_rst", level, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_addr_rst", address, 0);
    q.delete(); tcnt = 0; errm = 1'b0;
    @(negedge clk); rst_n = 1'b1; waitrequest = 1'b0;
    tick();
    push(9'h1AB, 32'hCAFEF00D);
    tick();
    check("t5_fresh_wr", write, 1);
    check("t5_fresh_addr", address, 9'h1AB);
    tick();
    check("t5_fresh_done", level, 0);

`ifdef CTL_SEQ_TIMEOUT_EN
    // stuck waitrequest aborts after TMO stall cycles
    waitrequest = 1'b1;
    c0 = ncomp; d0 = ndrop; n = 0;
    for (int i = 0; i < 30; i++) begin
      cmd_valid = (i < 2); cmd_addr = 9'(300 + i); cmd_data = $urandom;
      tick();
      if (write) n++;
      else if (n > 0) break;
    end
    cmd_valid = 1'b0;
    check("t6_len", n, TMO);
    check("t6_err", timeout_err, 1);
    waitrequest = 1'b0;
    tick();
    check("t6_next_wr", write, 1);
    tick();
    check("t6_dropped", ndrop - d0, 1);
    check("t6_ncomp", ncomp - c0, 1);
    check("t6_sticky", timeout_err, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("t6_cleared", timeout_err, 0);
`else
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("t6_err_tied", timeout_err, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid   = 1'($urandom_range(0, 1));
      cmd_addr    = 9'($urandom);
      cmd_data    = $urandom;
      waitrequest = ($urandom_range(0, 9) < 3);
      hold        = ($urandom_range(0, 9) == 0);
      clr_err     = ($urandom_range(0, 19) == 0);
      tick();
    end
    cmd_valid = 1'b0; waitrequest = 1'b0; hold = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < 60 && (q.size() != 0 || write); i++) tick();
    check("t7_drain", q.size(), 0);
    check("t7_idle", write, 0);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
